bcd_to_bin_seq: RTL
===================

# bcd_to_bin_seq

Sequential, parametrised BCD-to-binary converter; the multi-digit successor of the fixed three-digit units/tens/hundreds converter used on the board for angle entry. It accepts a packed BCD word under a ready/start handshake, folds one digit per cycle MSD-first (acc = acc*10 + digit), then presents a registered binary result with a one-cycle done pulse. It flags invalid BCD digits and, optionally, out-of-range results, e.g. degrees above 359.

## Interface
- DIGITS, 3, number of BCD digits in i_bcd (1..6)
- OUT_W, 9, width of o_bin; must satisfy 2**OUT_W > MAX_VAL
- MAX_VAL, 359, largest legal result (used only with range checking)
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  request; accepted only when o_ready=1
- i_bcd  in  4*DIGITS  packed BCD; [4*DIGITS-1 -: 4] is the MSD
- o_ready  out  1  high only in IDLE
- o_busy  out  1  high in CONV and DONE
- o_done  out  1  one-cycle pulse; result valid
- o_bin  out  OUT_W  result; held until the next o_done
- o_err  out  1  at least one digit >9 in the last conversion; held with o_bin
- o_range  out  1  last result exceeded MAX_VAL; held with o_bin

## Operation
- Internal accumulator width ACC_W = $clog2(10**DIGITS); no overflow is possible inside.
- FSM: IDLE -> CONV on i_start&&o_ready. CONV -> DONE after DIGITS digit steps. DONE -> IDLE unconditionally.
- IDLE, on accept: latch i_bcd into shift register, clear acc, digit counter and the sticky error.
- CONV, each cycle: d = top nibble; if d>9 then d=9 and set sticky error; acc <= acc*10+d; shift left 4; counter++.
- acc*10 is computed as (acc<<3)+(acc<<1); no multiplier.
- On the final step, register o_bin, o_err and o_range from the final acc, and set o_done.
- i_start outside IDLE is ignored, including during CONV and DONE; there is no queueing.
- i_bcd is sampled only at the accept edge; later changes have no effect.
- Reset values: state IDLE; o_ready=1; o_busy=0; o_done=0; o_bin=0; o_err=0; o_range=0; acc, shift register and counter 0.
- i_rst during CONV or DONE aborts the conversion. No o_done is issued, and o_bin is cleared to 0.
- i_rst has priority over i_start in the same cycle.

## Timing
- Accept edge E0: i_start=1 and o_ready=1.
- Edges E1..E_DIGITS: one digit each. At E_DIGITS the outputs are registered and the state becomes DONE.
- o_done is high for exactly the one cycle between E_DIGITS and E_DIGITS+1.
- Latency from the accept edge to the o_done cycle is DIGITS cycles.
- Earliest next accept is E_DIGITS+2, so throughput is one conversion per DIGITS+2 cycles.
- o_ready and o_busy are decoded from the state register only. There is no combinational path from any input.

## Configuration
- BCD_RANGE_CHECK_EN defined:
  - Final acc is compared with MAX_VAL.
  - If acc > MAX_VAL, then o_bin = MAX_VAL (clamped) and o_range = 1.
  - Otherwise o_bin = acc and o_range = 0.
- BCD_RANGE_CHECK_EN undefined:
  - No comparator.
  - o_bin = acc[OUT_W-1:0] (truncated).
  - o_range is tied to 0.
- o_err behaviour is identical in both builds.

## Structure
- Shared package bcd_pkg holds:
  - state enum (IDLE, CONV, DONE)
  - BCD_DIGIT_MAX = 4'd9
  - BCD_W = 4
- One sub-module, bcd_mac10: combinational, parametrised on ACC_W.
  - Inputs acc and nibble; outputs acc*10 + saturated digit and a digit_invalid flag.
  - Instantiated once in the top level.

## Test plan
- Default params, i_bcd=12'h275 -> o_done in the 3rd cycle after accept, o_bin=275, o_err=0, o_range=0. Back-to-back i_start is accepted again at E5.
- i_bcd=12'h999, BCD_RANGE_CHECK_EN defined -> o_bin=359, o_range=1. Undefined -> o_bin=999 mod 512=487, o_range=0.
- i_bcd=12'h1A5 -> digit A saturates to 9, o_bin=195, o_err=1. The next conversion of 12'h100 gives o_err=0, o_bin=100.
- i_start held high through CONV/DONE with i_bcd changing to 12'h050 -> first result unchanged (12'h275 gives 275); 050 is accepted only at the next IDLE and gives 50.
- i_rst=1 at E2 of a conversion -> no o_done; o_bin=0, o_ready=1 next cycle. The same-cycle i_rst+i_start is not accepted.
- DIGITS=4, OUT_W=14, MAX_VAL=9999, i_bcd=16'h9999 -> o_bin=9999 after 4 cycles, o_range=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   BCD_W          width of one BCD digit
//   BCD_DIGIT_MAX  largest legal BCD digit; larger nibbles saturate to this
//   bcd_state_e    converter FSM states
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle of the BCD-to-binary converter.
//   i_start  request, taken only while o_ready is high
//   i_bcd    packed BCD word, MSD in the top nibble
//   o_ready  converter idle
//   o_busy   conversion in progress or result cycle
//   o_done   one-cycle pulse, result valid
//   o_bin    binary result, held until the next o_done
//   o_err    some digit of the last word was above 9
//   o_range  last result exceeded the legal maximum
// master: requester side, slave: converter side.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 9
) ();

  logic                             i_start;
  logic [bcd_pkg::BCD_W*DIGITS-1:0] i_bcd;
  logic                             o_ready;
  logic                             o_busy;
  logic                             o_done;
  logic [OUT_W-1:0]                 o_bin;
  logic                             o_err;
  logic                             o_range;

  modport master (
    output i_start, i_bcd,
    input  o_ready, o_busy, o_done, o_bin, o_err, o_range
  );

  modport slave (
    input  i_start, i_bcd,
    output o_ready, o_busy, o_done, o_bin, o_err, o_range
  );

endinterface

// File: rtl/bcd_mac10.sv
// One digit step of the BCD fold: acc_o = acc_i*10 + digit.
//   acc_i            running accumulator
//   nibble_i         current BCD digit (may be illegal)
//   acc_o            updated accumulator
//   digit_invalid_o  nibble_i was above 9; it was folded in as 9
// The caller guarantees acc_i*10+9 fits in ACC_W bits.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [BCD_W-1:0] nibble_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             digit_invalid_o
);

  logic [BCD_W-1:0] digit_sat;

  assign digit_invalid_o = (nibble_i > BCD_DIGIT_MAX);
  assign digit_sat       = digit_invalid_o ? BCD_DIGIT_MAX : nibble_i;

  // x*10 as x*8 + x*2, no multiplier
  assign acc_o = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_sat);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one digit per cycle, MSD first.
//   i_clk   clock, rising edge
//   i_rst   synchronous active-high reset; aborts a running conversion
//   bus     request/result bundle (bcd_to_bin_seq_if.slave)
// Optional build macro BCD_RANGE_CHECK_EN: clamp results above MAX_VAL
// to MAX_VAL and flag o_range; otherwise the result is truncated to OUT_W
// bits and o_range stays 0.
//
// state | meaning
// IDLE  | o_ready high, waiting for i_start
// CONV  | folding one digit per cycle into the accumulator
// DONE  | result registered, o_done pulse; back to IDLE next cycle
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int OUT_W   = 9,
  parameter int MAX_VAL = 359
) (
  input  logic             i_clk,
  input  logic             i_rst,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int ACC_W = $clog2(10 ** DIGITS);
  localparam int SR_W  = BCD_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CONV = CONV;
  localparam logic [1:0] S_DONE = DONE;

  if ((2 ** OUT_W) <= MAX_VAL) begin : g_bad_out_w
    $error("bcd_to_bin_seq: OUT_W too narrow for MAX_VAL");
  end

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_err_q, sticky_err_d;
  logic [OUT_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;
  logic             range_q, range_d;
  logic             done_q, done_d;

  logic [ACC_W-1:0] acc_step;
  logic             digit_bad;
  logic [OUT_W-1:0] res_bin;
  logic             res_range;

  bcd_mac10 #(
    .ACC_W (ACC_W)
  ) u_mac10 (
    .acc_i           (acc_q),
    .nibble_i        (sr_q[SR_W-1 -: BCD_W]),
    .acc_o           (acc_step),
    .digit_invalid_o (digit_bad)
  );

`ifdef BCD_RANGE_CHECK_EN
  always_comb begin
    res_bin   = OUT_W'(acc_step);
    res_range = 1'b0;
    if (acc_step > ACC_W'(MAX_VAL)) begin
      res_bin   = OUT_W'(MAX_VAL);
      res_range = 1'b1;
    end
  end
`else
  assign res_bin   = OUT_W'(acc_step);
  assign res_range = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    sticky_err_d = sticky_err_q;
    bin_d        = bin_q;
    err_d        = err_q;
    range_d      = range_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d      = S_CONV;
          acc_d        = '0;
          sr_d         = bus.i_bcd;
          cnt_d        = '0;
          sticky_err_d = 1'b0;
        end
      end
      S_CONV: begin
        acc_d        = acc_step;
        sr_d         = sr_q << BCD_W;
        cnt_d        = cnt_q + CNT_W'(1);
        sticky_err_d = sticky_err_q | digit_bad;
        if (cnt_q == CNT_LAST) begin
          // results come straight from the final step, not from acc_q
          state_d = S_DONE;
          bin_d   = res_bin;
          err_d   = sticky_err_q | digit_bad;
          range_d = res_range;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      sr_q         <= '0;
      cnt_q        <= '0;
      sticky_err_q <= 1'b0;
      bin_q        <= '0;
      err_q        <= 1'b0;
      range_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      sticky_err_q <= sticky_err_d;
      bin_q        <= bin_d;
      err_q        <= err_d;
      range_q      <= range_d;
      done_q       <= done_d;
    end
  end

  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_busy  = (state_q == S_CONV) || (state_q == S_DONE);
  assign bus.o_done  = done_q;
  assign bus.o_bin   = bin_q;
  assign bus.o_err   = err_q;
  assign bus.o_range = range_q;

endmodule
